serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  requester presents operands.
REQ-005 SHALL have port in_ready  output  1  controller accepts operands.
REQ-006 SHALL have ports a, b  input  WIDTH  operands, unsigned / two's complement.
REQ-007 SHALL have port cin  input  1  carry-in, sampled with a, b.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port sum  output  WIDTH  result bits.
REQ-011 SHALL have port cout  output  1  final carry-out.
REQ-012 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-013 SHALL sequence one 1-bit full adder over WIDTH cycles, LSB first, as a bit-serial adder.
REQ-014 SHALL implement states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready edge SHALL capture a, b into shift registers, carry_q<=cin, bit counter<=0, go RUN.
REQ-016 RUN: each edge SHALL feed a_sh[0], b_sh[0], carry_q to the adder; shift sum bit in at MSB of sum register; shift a_sh, b_sh right; carry_q<=adder carry; counter++.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge where counter==WIDTH-1 SHALL go DONE; WIDTH=1 gives one RUN cycle.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH+1 edges after the accepting edge.
REQ-019 DONE: sum, cout SHALL hold stable until out_valid&&out_ready; on that edge SHALL return to IDLE.
REQ-020 in_valid during RUN or DONE SHALL be ignored; no operand captured, no state change.
REQ-021 out_ready during IDLE or RUN SHALL have no effect.
REQ-022 Arithmetic SHALL equal {cout,sum} = a + b + cin modulo 2^(WIDTH+1).
REQ-023 Back-to-back: earliest next accept SHALL be the cycle after the DONE handshake (one IDLE cycle minimum).

Reset
REQ-024 rst high SHALL immediately force IDLE, clearing shift registers, counter, carry_q, sum=0, cout=0, out_valid=0, busy=0.
REQ-025 rst mid-RUN or mid-DONE SHALL abort the operation with no result emitted; first accept after rst release SHALL compute correctly.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN defined SHALL add output port ovf (1 bit) = carry into MSB XOR cout, valid with out_valid, held in DONE, reset 0.
REQ-027 Macro SERIAL_ADD_OVF_EN undefined SHALL omit port ovf and its logic; all other behaviour identical.

Structure
REQ-028 Package serial_add_pkg SHALL hold state typedef (IDLE, RUN, DONE) and constant DEFAULT_WIDTH=8.
REQ-029 Counter width SHALL be $clog2(WIDTH+1), derived locally.
REQ-030 Sub-module fa_cell (a, b, cin -> sum, carry, combinational) SHALL be instantiated once as the shared adder datapath.

Verification
REQ-031 WIDTH=8, a=3, b=5, cin=0 -> sum=8, cout=0, out_valid rises 9 edges after accept.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 SERIAL_ADD_OVF_EN, a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1.
REQ-034 out_ready low 5 cycles in DONE, in_valid pulsed during RUN -> sum/cout stable, in_ready=0, pulse ignored, one result only.
REQ-035 rst asserted at RUN cycle 3 -> out_valid=0, busy=0 same cycle; next op a=0x10, b=0x20 -> sum=0x30.
REQ-036 WIDTH=1, a=1, b=1, cin=1 -> sum=1, cout=1, out_valid 2 edges after accept; 100 random back-to-back ops match a+b+cin.

Source files
------------

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared types and constants for the bit-serial adder
//                controller: FSM state encoding and the default operand
//                width.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : fa_cell
//  Description : Combinational 1-bit full adder. This is the only arithmetic
//                element of the serial adder; it is reused on every bit.
//  Ports       : a, b, cin  - addend bits and carry in
//                sum, carry - sum bit and carry out
//  Revision    : 1.0  initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder with valid/ready handshakes. Operands are
//                captured in IDLE, added LSB first over WIDTH RUN cycles with
//                a single full adder, and presented in DONE until consumed.
//  Ports       : clk, rst (async, active-high)
//                in_valid / in_ready, a, b, cin   - operand handshake
//                out_valid / out_ready, sum, cout - result handshake
//                busy                             - high in RUN and DONE
//                ovf (only with SERIAL_ADD_OVF_EN) - signed overflow flag
//  Config      : `define SERIAL_ADD_OVF_EN adds the ovf output.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int            CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              w_fa_sum;
    logic              w_fa_carry;
    // New sum bit enters at the MSB; the widened vector keeps the slice legal
    // for WIDTH == 1.
    logic [WIDTH:0]    w_sum_ext;

    fa_cell u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    assign w_sum_ext = {w_fa_sum, sum_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = w_sum_ext[WIDTH:1];
                carry_d = w_fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // On the MSB cycle carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ w_fa_carry;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    // After the last RUN cycle the carry register holds the final carry-out.
    assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl. Two instances are
//                exercised: WIDTH=8 (index 0) and WIDTH=1 (index 1). Results
//                are compared with a plain-arithmetic reference a+b+cin.
//                Define SERIAL_ADD_OVF_EN to also check the ovf output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] iv   = '0;
    logic [1:0] ordy = '0;
    logic [1:0] ir, ov, co, bsy, cn;
    logic [1:0] ovfs;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic [0:0] a1 = '0, b1 = '0, s1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a8), .b(b8), .cin(cn[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s8), .cout(co[0]),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovfs[0]),
`endif
        .busy(bsy[0])
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a1), .b(b1), .cin(cn[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .cout(co[1]),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovfs[1]),
`endif
        .busy(bsy[1])
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovfs = '0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] get_sum(input int d);
        return (d == 0) ? s8 : {7'b0, s1};
    endfunction

    // Presents one operation on instance d, waits for the result, optionally
    // stalls the consumer for 'hold' cycles, then completes the handshake.
    // 'pulse' injects a stray in_valid and out_ready while the adder runs.
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input int hold, input logic pulse);
        int          w;
        int          edges;
        int          n;
        logic [8:0]  full;
        logic [7:0]  es;
        logic        ec;
        logic        eo;
        logic [7:0]  held;
        logic        msb_a, msb_b, msb_s;

        w = (d == 0) ? 8 : 1;
        if (d == 0) begin
            full  = 9'(av) + 9'(bv) + 9'(cv);
            es    = full[7:0];
            ec    = full[8];
            msb_a = av[7]; msb_b = bv[7]; msb_s = es[7];
        end else begin
            full  = 9'(av[0]) + 9'(bv[0]) + 9'(cv);
            es    = {7'b0, full[0]};
            ec    = full[1];
            msb_a = av[0]; msb_b = bv[0]; msb_s = es[0];
        end
        // Two's complement overflow: equal operand signs, different result sign.
        eo = (msb_a == msb_b) && (msb_s != msb_a);

        if (d == 0) begin a8 = av; b8 = bv; end
        else        begin a1 = av[0]; b1 = bv[0]; end
        cn[d] = cv;
        iv[d] = 1'b1;

        n = 0;
        while (!ir[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!ir[d]) chk("accept_timeout", 64'(ir[d]), 64'd1);

        // Accepting edge is counted as edge 1.
        @(posedge clk); #1;
        edges = 1;
        iv[d] = 1'b0;
        if (d == 0) begin a8 = 8'($urandom); b8 = 8'($urandom); end
        else        begin a1 = 1'($urandom); b1 = 1'($urandom); end
        cn[d] = 1'($urandom);

        while (!ov[d] && edges < 40) begin
            iv[d]   = pulse && (edges == 3);
            ordy[d] = pulse && (edges == 3);
            @(posedge clk); #1;
            edges++;
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;

        chk("latency",  64'(edges), 64'(w + 1));
        chk("sum",      64'(get_sum(d)), 64'(es));
        chk("cout",     64'(co[d]), 64'(ec));
        chk("busy_done", 64'(bsy[d]), 64'd1);
        chk("in_ready_done", 64'(ir[d]), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf",      64'(ovfs[d]), 64'(eo));
`else
        if (eo === 1'bx) chk("ovf_model", 64'(eo), 64'd0);
`endif

        held = get_sum(d);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(ov[d]), 64'd1);
            chk("hold_sum",   64'(get_sum(d)), 64'(held));
            chk("hold_cout",  64'(co[d]), 64'(ec));
            chk("hold_in_ready", 64'(ir[d]), 64'd0);
        end

        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk("post_valid", 64'(ov[d]), 64'd0);
        chk("post_ready", 64'(ir[d]), 64'd1);
        chk("post_busy",  64'(bsy[d]), 64'd0);
    endtask

    initial begin
        cn = '0;
        // Reset state, checked while rst is held.
        #2;
        chk("rst_in_ready",  64'(ir),  64'b11);
        chk("rst_out_valid", 64'(ov),  64'b00);
        chk("rst_busy",      64'(bsy), 64'b00);
        chk("rst_sum",       64'(s8),  64'd0);
        chk("rst_cout",      64'(co),  64'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, WIDTH=8.
        run_op(0, 8'd3,   8'd5,   1'b0, 0, 1'b0);
        run_op(0, 8'hFF,  8'h01,  1'b0, 0, 1'b0);
        run_op(0, 8'hFF,  8'h00,  1'b1, 0, 1'b0);
        run_op(0, 8'h7F,  8'h01,  1'b0, 0, 1'b0);
        run_op(0, 8'h80,  8'h80,  1'b0, 0, 1'b0);
        // Consumer stall plus stray in_valid/out_ready during RUN.
        run_op(0, 8'hA5,  8'h3C,  1'b1, 5, 1'b1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_extra_result", 64'(ov[0]), 64'd0);
        end

        // Abort by reset at RUN cycle 3.
        a8 = 8'h55; b8 = 8'h66; cn[0] = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_abort_busy", 64'(bsy[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(ov[0]),  64'd0);
        chk("abort_busy",  64'(bsy[0]), 64'd0);
        chk("abort_sum",   64'(s8),     64'd0);
        chk("abort_cout",  64'(co[0]),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            chk("abort_no_result", 64'(ov[0]), 64'd0);
        end
        run_op(0, 8'h10, 8'h20, 1'b0, 0, 1'b0);

        // WIDTH=1 directed and random back-to-back.
        run_op(1, 8'd1, 8'd1, 1'b1, 0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);
        end

        // WIDTH=8 random with random consumer stalls.
        for (int k = 0; k < 40; k++) begin
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
